// File: rtl/ram_arbiter_if.sv
// Port bundle between ram_arbiter, its two requesters (CPU on port 0, debug/loader on port 1)
// and the single-ported RAM behind it.
interface ram_arbiter_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 4
);
   logic              req0, req1;
   logic              we0, we1;
   logic [ADDR_W-1:0] addr0, addr1;
   logic [DATA_W-1:0] wdata0, wdata1;
   logic              gnt0, gnt1;
   logic              done0, done1;
   logic [DATA_W-1:0] rdata;
   logic              busy;
   logic              ram_cs, ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_rdata,
      output gnt0, gnt1, done0, done1, rdata, busy, ram_cs, ram_we, ram_addr, ram_wdata
   );

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_rdata,
      input  gnt0, gnt1, done0, done1, rdata, busy, ram_cs, ram_we, ram_addr, ram_wdata
   );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a single-ported RAM. Each access spends one cycle in ACCESS
// and one in RESP; a pending request chains from RESP straight into ACCESS.
module ram_arbiter #(
   parameter bit RR_MODE = 1'b1,
   parameter int ADDR_W  = 12,
   parameter int DATA_W  = 4
) (
   input logic          clk,
   input logic          reset,
   ram_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t            state, state_nxt;
   logic              owner, owner_nxt;
   logic              last_owner;
   logic              take, win;
   logic              lat_we, lat_we_nxt;
   logic [ADDR_W-1:0] lat_addr, lat_addr_nxt;
   logic [DATA_W-1:0] lat_wdata, lat_wdata_nxt;
   logic [DATA_W-1:0] rdata_q;

   // A tie goes to the port that did not own the previous access, or always to port 1.
   function automatic logic arbitrate(input logic r0, input logic r1, input logic last);
      if (r0 && r1) return RR_MODE ? ~last : 1'b1;
      return r1;
   endfunction

   assign win  = arbitrate(bus.req0, bus.req1, last_owner);
   assign take = (bus.req0 || bus.req1) && (state != ACCESS);

   always_comb begin
      state_nxt     = state;
      owner_nxt     = owner;
      lat_we_nxt    = lat_we;
      lat_addr_nxt  = lat_addr;
      lat_wdata_nxt = lat_wdata;
      case (state)
         IDLE:    if (take) state_nxt = ACCESS;
         ACCESS:  state_nxt = RESP;
         RESP:    state_nxt = take ? ACCESS : IDLE;
         default: state_nxt = IDLE;
      endcase
      if (take) begin
         owner_nxt     = win;
         lat_we_nxt    = win ? bus.we1    : bus.we0;
         lat_addr_nxt  = win ? bus.addr1  : bus.addr0;
         lat_wdata_nxt = win ? bus.wdata1 : bus.wdata0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         owner      <= 1'b0;
         last_owner <= 1'b1;
         lat_we     <= 1'b0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         rdata_q    <= '0;
      end else begin
         owner     <= owner_nxt;
         lat_we    <= lat_we_nxt;
         lat_addr  <= lat_addr_nxt;
         lat_wdata <= lat_wdata_nxt;
         // Closing the RAM cycle: remember the owner for the next tie, capture read data.
         if (state == ACCESS) begin
            last_owner <= owner;
            if (!lat_we) rdata_q <= bus.ram_rdata;
         end
      end
   end

   assign bus.gnt0      = (state == ACCESS) && !owner;
   assign bus.gnt1      = (state == ACCESS) &&  owner;
   assign bus.done0     = (state == RESP)   && !owner;
   assign bus.done1     = (state == RESP)   &&  owner;
   assign bus.busy      = (state != IDLE);
   assign bus.ram_cs    = (state == ACCESS);
   assign bus.ram_we    = (state == ACCESS) && lat_we;
   assign bus.ram_addr  = lat_addr;
   assign bus.ram_wdata = lat_wdata;
   assign bus.rdata     = rdata_q;
endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter RR_MODE, default 1, meaning 1 = round-robin between ports, 0 = fixed priority with port 1 winning.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req0, req1  input  1 each  access request from port 0 (CPU) and port 1 (debug/loader).
REQ-005 we0, we1  input  1 each  1 = write, 0 = read; valid while the matching req is high.
REQ-006 addr0, addr1  input  12 each  RAM address, valid while the matching req is high.
REQ-007 wdata0, wdata1  input  4 each  write nibble, valid while the matching req is high.
REQ-008 gnt0, gnt1  output  1 each  one-cycle grant pulse; request captured.
REQ-009 done0, done1  output  1 each  one-cycle completion pulse; read data valid on rdata.
REQ-010 rdata  output  4  read nibble for the port whose done is high; holds its last value otherwise.
REQ-011 busy  output  1  high while state is not IDLE.
REQ-012 ram_cs, ram_we  output  1 each  RAM chip select and write enable.
REQ-013 ram_addr  output  12 and ram_wdata output 4  RAM address and write data.
REQ-014 ram_rdata  input  4  RAM read data; the tri-state bus wrapper is outside this block.

Function
REQ-015 FSM states SHALL be IDLE, ACCESS and RESP, with all outputs driven from registers or from state only.
REQ-016 IDLE: if no req, stay. If any req, arbitrate, latch the winner's id, we, addr and wdata, assert its gnt for the next cycle, and go to ACCESS.
REQ-017 Arbitration, RR_MODE=1: a single requester wins. If both request, the port other than last_owner wins. last_owner resets to 1, so port 0 wins the first tie.
REQ-018 Arbitration, RR_MODE=0: port 1 wins every tie, and last_owner is still updated.
REQ-019 ACCESS (exactly 1 cycle): ram_cs=1; ram_we=latched we; ram_addr and ram_wdata=latched values; gnt of the owner=1.
REQ-020 At the ACCESS->RESP edge, for a read, rdata SHALL capture ram_rdata. For a write, rdata is unchanged. last_owner SHALL be set to the owner.
REQ-021 RESP (exactly 1 cycle): done of the owner=1; ram_cs=0; ram_we=0.
REQ-022 RESP exit: if any req is high, arbitrate per REQ-017/018 using the updated last_owner and go directly to ACCESS. Otherwise go to IDLE.
REQ-023 Latency: req sampled high at edge N gives gnt high in cycle N+1 and done high in cycle N+2, when the arbiter is idle.
REQ-024 Throughput: back-to-back accesses SHALL complete every 2 cycles.
REQ-025 Requesters SHALL deassert req in the cycle after seeing gnt. A req held high SHALL be treated as a new request, not an error.
REQ-026 ram_we SHALL never be high while ram_cs is low. At most one gnt and at most one done SHALL be high in any cycle.
REQ-027 Requests arriving during ACCESS SHALL wait; they are sampled at RESP or IDLE.
REQ-028 Address and data SHALL pass through unmodified: no wrap, offset or width change.

Reset
REQ-029 Asynchronous reset SHALL force IDLE immediately. It SHALL clear gnt0/1, done0/1, ram_cs, ram_we and busy, and set ram_addr=0, ram_wdata=0, rdata=0 and last_owner=1.
REQ-030 Reset during ACCESS SHALL deassert ram_cs/ram_we immediately. The in-flight access is dropped, and no done is issued for it after reset.
REQ-031 After reset release, the first edge with req high SHALL start arbitration normally.

Verification
REQ-032 Single read: RAM[0x123]=0xA, req0 with we0=0 and addr0=0x123 -> gnt0 in the next cycle, done0 one cycle later, rdata=0xA, ram_we=0 throughout.
REQ-033 Write then read: port1 writes 0x5 to 0xFFF, then reads 0xFFF -> ram_cs=ram_we=1 with ram_addr=0xFFF and ram_wdata=0x5 in ACCESS; the read returns rdata=0x5 on done1.
REQ-034 Tie with RR_MODE=1: req0 and req1 held high for 4 grants from reset -> grant order 0,1,0,1, a done every 2 cycles, never two gnts in one cycle.
REQ-035 Tie with RR_MODE=0: req0 and req1 held high -> every grant goes to port 1 and port 0 is never granted.
REQ-036 Reset mid-ACCESS: assert reset while ram_cs=1 -> ram_cs, ram_we and gnt drop without waiting for a clock edge, no done follows, busy=0, and the next req0 is granted normally.
